iob2axil: RTL and testbench
===========================

// Module: iob2axil
// PURPOSE
//  IOb-bus slave to AXI4-Lite master bridge; the counterpart of the AXIL-to-IOb peripheral bridge.
//  Lets an IOb-native master (CPU-side IOb port, DMA, boot controller) reach AXI-Lite slaves on the SoC interconnect.
//  Carries one transaction at a time: the IOb request is registered, the AXI-Lite channel handshakes are driven,
//  and a read response or write completion is returned to IOb. Write = wstrb != 0; read = wstrb == 0.
// PARAMETERS
//  ADDR_W   32  IOb and AXIL address width
//  DATA_W   32  IOb and AXIL data width (multiple of 8); wstrb width = DATA_W/8
// PORTS
//  clk_i           in   1         clock; all logic on rising edge
//  rst_i           in   1         synchronous reset, active-high
//  cke_i           in   1         clock enable; when 0, all state and outputs hold
//  iob_avalid_i    in   1         IOb request valid
//  iob_addr_i      in   ADDR_W    IOb address
//  iob_wdata_i     in   DATA_W    IOb write data
//  iob_wstrb_i     in   DATA_W/8  IOb write strobe; 0 = read
//  iob_rvalid_o    out  1         read data valid (1-cycle pulse)
//  iob_rdata_o     out  DATA_W    read data
//  iob_ready_o     out  1         request accepted when avalid_i & ready_o
//  axil_awaddr_o/awprot_o(3)/awvalid_o  out;  axil_awready_i  in
//  axil_wdata_o/wstrb_o/wvalid_o        out;  axil_wready_i   in
//  axil_bresp_o-side: axil_bresp_i(2), axil_bvalid_i  in;  axil_bready_o  out
//  axil_araddr_o/arprot_o(3)/arvalid_o  out;  axil_arready_i  in
//  axil_rdata_i(DATA_W), axil_rresp_i(2), axil_rvalid_i  in;  axil_rready_o  out
//  err_o           out  1         1-cycle pulse when bresp/rresp != OKAY
// BEHAVIOUR
//  Reset: state=IDLE; iob_ready_o=1; iob_rvalid_o=0; iob_rdata_o=0; all axil valid/ready outputs=0;
//   axil addr/data/strb=0; prot=3'b000 (constant); err_o=0.
//  FSM states: IDLE, WRITE, WRESP, READ, RDATA.
//  IDLE: iob_ready_o=1. On avalid_i: register addr/wdata/wstrb and drop ready_o next cycle.
//   wstrb!=0 -> WRITE with awvalid_o=wvalid_o=1; wstrb==0 -> READ with arvalid_o=1.
//  WRITE: AW and W complete independently. awvalid_o clears on the cycle after awready_i; wvalid_o clears
//   the cycle after wready_i. Both may complete in the same cycle, in either order, or AW/W may be accepted
//   before the other valid. Once both have completed -> WRESP with bready_o=1.
//  WRESP: on bvalid_i: bready_o=0, err_o pulses if bresp_i!=0, -> IDLE. iob_ready_o returns 1 the cycle after B,
//   so writes complete strictly in order and no rvalid is issued for writes.
//  READ: on arready_i: arvalid_o=0, -> RDATA with rready_o=1.
//  RDATA: on rvalid_i: capture rdata_i into iob_rdata_o, iob_rvalid_o=1 for exactly 1 cycle, err_o pulses if
//   rresp_i!=0, rready_o=0, -> IDLE. On error, rdata is still forwarded unchanged.
//  Latency, zero-wait AXI slave:
//   read  = avalid -> ar (cycle+1) -> r (cycle+2) -> rvalid_o (cycle+3)
//   write = avalid -> aw/w (cycle+1) -> b (cycle+2) -> ready_o=1 (cycle+3)
//  Valid stability: axil valids and payloads hold until their handshake; they never drop early (AXI rule).
//  Back-to-back: an avalid_i present in the same cycle ready_o returns to 1 is accepted; max 1 outstanding.
//  iob_rdata_o holds its last value until the next read completes.
//  avalid_i while ready_o=0 is ignored; the master must hold the request.
//  rst_i mid-transaction: immediate return to reset values. Any open AXI transaction is abandoned; the system
//   resets the interconnect with the same reset.
//  cke_i=0 freezes the FSM; handshake inputs seen during a freeze are not sampled.
//  Spurious bvalid_i/rvalid_i outside WRESP/RDATA are ignored (ready=0).
// STRUCTURE
//  Header iob2axil.vh: state encodings (3-bit localparams), AXI_RESP_OKAY=2'b00, AXI_PROT_DEFAULT=3'b000.
//  Single module, one FSM plus aw_done/w_done flags.
//  Payload registers use the codebase iob_reg (sync reset + cke variant); no other sub-module.
// TESTING
//  T1 read: avalid, addr=0x40, wstrb=0; slave gives rdata=0xDEADBEEF, rresp=0 at first opportunity
//   -> araddr_o=0x40; rvalid_o high 1 cycle at cycle+3; rdata_o=0xDEADBEEF; err_o=0.
//  T2 write, AW before W: addr=0x10, wdata=0x12345678, wstrb=4'b0011; awready at cycle 1, wready at cycle 4
//   -> awvalid_o drops after cycle 1; wvalid_o holds until cycle 4; bready after both; ready_o=1 after B.
//  T3 write, W before AW: wready at cycle 1, awready at cycle 3 -> same completion; wstrb_o=4'b0011 throughout.
//  T4 errors: read with rresp=2'b10 -> rvalid_o + err_o same cycle; write with bresp=2'b11 -> err_o pulse.
//  T5 back-to-back: read 0x0, write 0x4, read 0x4 with zero-wait slave -> correct AXI order; 2nd read returns
//   the written data; no overlap of ar/aw valids.
//  T6 reset mid-WRITE (awvalid high, no awready) -> next cycle all axil valids 0, ready_o=1, state IDLE;
//   a following read completes normally.
//  Also: stall with cke_i=0 for 5 cycles mid-READ -> outputs frozen.

Source files
------------

// File: rtl/iob2axil_pkg.sv
// Shared constants for the IOb-to-AXI4-Lite master bridge: FSM encodings and AXI
// response/protection codes.
package iob2axil_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_WRESP = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_RDATA = 3'd4;

  localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/iob2axil_reg.sv
// Payload register with synchronous active-high reset, clock enable and load enable.
module iob2axil_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cke,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: payload registers are reset as well because they drive AXI outputs directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (cke && en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/iob2axil.sv
// IOb slave to AXI4-Lite master bridge. One transaction in flight: the IOb request is
// registered, the AXI-Lite channels are handshaked, and the result is returned to IOb.
module iob2axil
  import iob2axil_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cke_i,
  input  logic                iob_avalid_i,
  input  logic [ADDR_W-1:0]   iob_addr_i,
  input  logic [DATA_W-1:0]   iob_wdata_i,
  input  logic [DATA_W/8-1:0] iob_wstrb_i,
  output logic                iob_rvalid_o,
  output logic [DATA_W-1:0]   iob_rdata_o,
  output logic                iob_ready_o,
  output logic [ADDR_W-1:0]   axil_awaddr_o,
  output logic [2:0]          axil_awprot_o,
  output logic                axil_awvalid_o,
  input  logic                axil_awready_i,
  output logic [DATA_W-1:0]   axil_wdata_o,
  output logic [DATA_W/8-1:0] axil_wstrb_o,
  output logic                axil_wvalid_o,
  input  logic                axil_wready_i,
  input  logic [1:0]          axil_bresp_i,
  input  logic                axil_bvalid_i,
  output logic                axil_bready_o,
  output logic [ADDR_W-1:0]   axil_araddr_o,
  output logic [2:0]          axil_arprot_o,
  output logic                axil_arvalid_o,
  input  logic                axil_arready_i,
  input  logic [DATA_W-1:0]   axil_rdata_i,
  input  logic [1:0]          axil_rresp_i,
  input  logic                axil_rvalid_i,
  output logic                axil_rready_o,
  output logic                err_o
);

  localparam int STRB_W = DATA_W / 8;

  logic [2:0]        state;
  logic              aw_done;
  logic              w_done;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  logic req_accept;
  logic rd_capture;
  logic aw_hs;
  logic w_hs;
  logic aw_ok;
  logic w_ok;

  assign iob_ready_o = (state == ST_IDLE);
  assign req_accept  = iob_avalid_i && iob_ready_o;
  assign rd_capture  = (state == ST_RDATA) && axil_rvalid_i;

  assign aw_hs = axil_awvalid_o && axil_awready_i;
  assign w_hs  = axil_wvalid_o && axil_wready_i;
  // A channel counts as complete if it finished earlier or is finishing this cycle.
  assign aw_ok = aw_done || aw_hs;
  assign w_ok  = w_done || w_hs;

  iob2axil_reg #(.W(ADDR_W)) u_addr_reg (
    .clk (clk_i),
    .rst (rst_i),
    .cke (cke_i),
    .en  (req_accept),
    .d   (iob_addr_i),
    .q   (addr_q)
  );

  iob2axil_reg #(.W(DATA_W)) u_wdata_reg (
    .clk (clk_i),
    .rst (rst_i),
    .cke (cke_i),
    .en  (req_accept),
    .d   (iob_wdata_i),
    .q   (wdata_q)
  );

  iob2axil_reg #(.W(STRB_W)) u_wstrb_reg (
    .clk (clk_i),
    .rst (rst_i),
    .cke (cke_i),
    .en  (req_accept),
    .d   (iob_wstrb_i),
    .q   (wstrb_q)
  );

  // Read data holds until the next completed read, even across writes.
  iob2axil_reg #(.W(DATA_W)) u_rdata_reg (
    .clk (clk_i),
    .rst (rst_i),
    .cke (cke_i),
    .en  (rd_capture),
    .d   (axil_rdata_i),
    .q   (iob_rdata_o)
  );

  assign axil_awaddr_o = addr_q;
  assign axil_araddr_o = addr_q;
  assign axil_wdata_o  = wdata_q;
  assign axil_wstrb_o  = wstrb_q;
  assign axil_awprot_o = AXI_PROT_DEFAULT;
  assign axil_arprot_o = AXI_PROT_DEFAULT;

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= ST_IDLE;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      axil_awvalid_o <= 1'b0;
      axil_wvalid_o  <= 1'b0;
      axil_bready_o  <= 1'b0;
      axil_arvalid_o <= 1'b0;
      axil_rready_o  <= 1'b0;
      iob_rvalid_o   <= 1'b0;
      err_o          <= 1'b0;
    end else if (cke_i) begin
      iob_rvalid_o <= 1'b0;
      err_o        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (iob_avalid_i) begin
            if (|iob_wstrb_i) begin
              state          <= ST_WRITE;
              axil_awvalid_o <= 1'b1;
              axil_wvalid_o  <= 1'b1;
              aw_done        <= 1'b0;
              w_done         <= 1'b0;
            end else begin
              state          <= ST_READ;
              axil_arvalid_o <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (aw_hs) begin
            axil_awvalid_o <= 1'b0;
            aw_done        <= 1'b1;
          end
          if (w_hs) begin
            axil_wvalid_o <= 1'b0;
            w_done        <= 1'b1;
          end
          if (aw_ok && w_ok) begin
            state         <= ST_WRESP;
            axil_bready_o <= 1'b1;
          end
        end
        ST_WRESP: begin
          if (axil_bvalid_i) begin
            state         <= ST_IDLE;
            axil_bready_o <= 1'b0;
            err_o         <= resp_is_err(axil_bresp_i);
          end
        end
        ST_READ: begin
          if (axil_arready_i) begin
            state          <= ST_RDATA;
            axil_arvalid_o <= 1'b0;
            axil_rready_o  <= 1'b1;
          end
        end
        ST_RDATA: begin
          if (axil_rvalid_i) begin
            state         <= ST_IDLE;
            axil_rready_o <= 1'b0;
            iob_rvalid_o  <= 1'b1;
            err_o         <= resp_is_err(axil_rresp_i);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iob2axil.sv
// Scoreboard bench for iob2axil: an IOb master issues requests against a reference memory
// model, an AXI-Lite slave model checks channel traffic, and an IOb monitor checks results.
module tb_iob2axil;

  typedef enum int {M_RND, M_FAST, M_HOLD} mode_t;

  typedef struct {
    bit          is_rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } axi_exp_t;

  typedef struct {
    bit          is_rd;
    logic [31:0] rdata;
    bit          err;
    int          lat;
    int          cyc0;
  } rsp_exp_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cke_i;
  logic        iob_avalid_i;
  logic [31:0] iob_addr_i;
  logic [31:0] iob_wdata_i;
  logic [3:0]  iob_wstrb_i;
  logic        iob_rvalid_o;
  logic [31:0] iob_rdata_o;
  logic        iob_ready_o;
  logic [31:0] axil_awaddr_o;
  logic [2:0]  axil_awprot_o;
  logic        axil_awvalid_o;
  logic        axil_awready_i;
  logic [31:0] axil_wdata_o;
  logic [3:0]  axil_wstrb_o;
  logic        axil_wvalid_o;
  logic        axil_wready_i;
  logic [1:0]  axil_bresp_i;
  logic        axil_bvalid_i;
  logic        axil_bready_o;
  logic [31:0] axil_araddr_o;
  logic [2:0]  axil_arprot_o;
  logic        axil_arvalid_o;
  logic        axil_arready_i;
  logic [31:0] axil_rdata_i;
  logic [1:0]  axil_rresp_i;
  logic        axil_rvalid_i;
  logic        axil_rready_o;
  logic        err_o;

  int       checks = 0;
  int       failures = 0;
  int       cyc = 0;
  mode_t    mode = M_FAST;
  bit       frz = 1'b0;
  bit       cke_rand = 1'b0;
  bit       cke_dir = 1'b1;

  axi_exp_t    axi_q[$];
  rsp_exp_t    rsp_q[$];
  logic [31:0] model_mem [64];
  logic [31:0] slv_mem [64];

  iob2axil #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .cke_i          (cke_i),
    .iob_avalid_i   (iob_avalid_i),
    .iob_addr_i     (iob_addr_i),
    .iob_wdata_i    (iob_wdata_i),
    .iob_wstrb_i    (iob_wstrb_i),
    .iob_rvalid_o   (iob_rvalid_o),
    .iob_rdata_o    (iob_rdata_o),
    .iob_ready_o    (iob_ready_o),
    .axil_awaddr_o  (axil_awaddr_o),
    .axil_awprot_o  (axil_awprot_o),
    .axil_awvalid_o (axil_awvalid_o),
    .axil_awready_i (axil_awready_i),
    .axil_wdata_o   (axil_wdata_o),
    .axil_wstrb_o   (axil_wstrb_o),
    .axil_wvalid_o  (axil_wvalid_o),
    .axil_wready_i  (axil_wready_i),
    .axil_bresp_i   (axil_bresp_i),
    .axil_bvalid_i  (axil_bvalid_i),
    .axil_bready_o  (axil_bready_o),
    .axil_araddr_o  (axil_araddr_o),
    .axil_arprot_o  (axil_arprot_o),
    .axil_arvalid_o (axil_arvalid_o),
    .axil_arready_i (axil_arready_i),
    .axil_rdata_i   (axil_rdata_i),
    .axil_rresp_i   (axil_rresp_i),
    .axil_rvalid_i  (axil_rvalid_i),
    .axil_rready_o  (axil_rready_o),
    .err_o          (err_o)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Clock-enable driver; changes land mid-cycle so every edge sees a stable value.
  initial begin
    cke_i = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      cke_i = cke_rand ? (($urandom % 5) != 0) : cke_dir;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave reports an error for the top quarter of the 64-word window.
  function automatic bit err_addr(input logic [31:0] a);
    return a[7:6] == 2'b11;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // AXI-Lite slave model with its own memory; checks channel payloads against the
  // expected-transaction queue and the valid-stability rule.
  initial begin : slave
    bit got_aw, got_w, b_pend, r_pend, b_shown, r_shown;
    bit p_awv, p_wv, p_arv, p_bready, p_rready, p_cke, p_rst;
    logic [31:0] p_awaddr, p_wdata, p_araddr, aw_a, w_d, r_d;
    logic [3:0]  p_wstrb, w_s;
    logic [1:0]  b_r, r_r;
    axi_exp_t    e;
    got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0; b_shown = 0; r_shown = 0;
    p_awv = 0; p_wv = 0; p_arv = 0; p_bready = 0; p_rready = 0; p_cke = 0; p_rst = 1;
    p_awaddr = '0; p_wdata = '0; p_araddr = '0; p_wstrb = '0;
    aw_a = '0; w_d = '0; r_d = '0; w_s = '0; b_r = '0; r_r = '0;
    axil_awready_i = 0; axil_wready_i = 0; axil_arready_i = 0;
    axil_bvalid_i = 0; axil_bresp_i = 0; axil_rvalid_i = 0; axil_rresp_i = 0; axil_rdata_i = 0;
    forever begin
      @(negedge clk);
      if (p_rst) begin
        got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0; b_shown = 0; r_shown = 0;
      end else if (p_cke) begin
        if (p_awv && !axil_awready_i) check("awvalid_hold", axil_awvalid_o, 1);
        if (p_wv && !axil_wready_i)   check("wvalid_hold", axil_wvalid_o, 1);
        if (p_arv && !axil_arready_i) check("arvalid_hold", axil_arvalid_o, 1);
        if (p_bready && axil_bvalid_i && b_shown) begin b_pend = 0; b_shown = 0; end
        if (p_rready && axil_rvalid_i && r_shown) begin r_pend = 0; r_shown = 0; end
        if (p_awv && axil_awready_i) begin got_aw = 1; aw_a = p_awaddr; end
        if (p_wv && axil_wready_i) begin got_w = 1; w_d = p_wdata; w_s = p_wstrb; end
        if (got_aw && got_w) begin
          if (axi_q.size() == 0) check("axi_unexpected_write", 1, 0);
          else begin
            e = axi_q.pop_front();
            check("axi_kind_write", e.is_rd, 0);
            check("awaddr", aw_a, e.addr);
            check("wdata", w_d, e.data);
            check("wstrb", w_s, e.strb);
          end
          if (!err_addr(aw_a)) slv_mem[aw_a[7:2]] = merge(slv_mem[aw_a[7:2]], w_d, w_s);
          b_r = err_addr(aw_a) ? 2'b11 : 2'b00;
          b_pend = 1; got_aw = 0; got_w = 0;
        end
        if (p_arv && axil_arready_i) begin
          if (axi_q.size() == 0) check("axi_unexpected_read", 1, 0);
          else begin
            e = axi_q.pop_front();
            check("axi_kind_read", e.is_rd, 1);
            check("araddr", p_araddr, e.addr);
          end
          r_d = slv_mem[p_araddr[7:2]];
          r_r = err_addr(p_araddr) ? 2'b10 : 2'b00;
          r_pend = 1;
        end
      end
      check("ar_aw_overlap", axil_arvalid_o && (axil_awvalid_o || axil_wvalid_o), 0);
      check("prot", {axil_awprot_o, axil_arprot_o}, 6'b0);
      if ((axil_awvalid_o || axil_wvalid_o) && !got_aw && axi_q.size() > 0)
        check("awaddr_payload", axil_awaddr_o, axi_q[0].addr);
      if (axil_wvalid_o && axi_q.size() > 0)
        check("wdata_payload", {axil_wstrb_o, axil_wdata_o}, {axi_q[0].strb, axi_q[0].data});
      case (mode)
        M_FAST: begin
          axil_awready_i = 1; axil_wready_i = 1; axil_arready_i = 1;
        end
        M_HOLD: begin
          axil_awready_i = frz; axil_wready_i = frz; axil_arready_i = frz;
        end
        default: begin
          axil_awready_i = $urandom % 2; axil_wready_i = $urandom % 2; axil_arready_i = $urandom % 2;
        end
      endcase
      if (b_pend && (mode == M_FAST || (mode == M_RND && ($urandom % 2) == 1))) b_shown = 1;
      if (r_pend && (mode == M_FAST || (mode == M_RND && ($urandom % 2) == 1))) r_shown = 1;
      // Spurious responses outside a pending transaction must be ignored by the bridge.
      axil_bvalid_i = b_shown || (!b_pend && mode == M_RND && ($urandom % 8) == 0);
      axil_bresp_i  = b_shown ? b_r : 2'b11;
      axil_rvalid_i = r_shown || (!r_pend && mode == M_RND && ($urandom % 8) == 0);
      axil_rresp_i  = r_shown ? r_r : 2'b10;
      axil_rdata_i  = r_shown ? r_d : $urandom;
      p_awv = axil_awvalid_o; p_wv = axil_wvalid_o; p_arv = axil_arvalid_o;
      p_bready = axil_bready_o; p_rready = axil_rready_o;
      p_awaddr = axil_awaddr_o; p_wdata = axil_wdata_o; p_wstrb = axil_wstrb_o;
      p_araddr = axil_araddr_o; p_cke = cke_i; p_rst = rst_i;
    end
  end

  // IOb monitor: a rising ready_o marks the end of a transaction.
  initial begin : iob_mon
    bit prev_ready, pc, prst;
    rsp_exp_t e;
    prev_ready = 1; pc = 0; prst = 1;
    forever begin
      @(negedge clk);
      if (!prst && pc) begin
        if (!prev_ready && iob_ready_o) begin
          if (rsp_q.size() == 0) check("iob_unexpected_done", 1, 0);
          else begin
            e = rsp_q.pop_front();
            check("rvalid", iob_rvalid_o, e.is_rd);
            if (e.is_rd) check("rdata", iob_rdata_o, e.rdata);
            check("err", err_o, e.err);
            if (e.lat > 0) check("latency", cyc - e.cyc0, e.lat);
          end
        end else begin
          check("rvalid_idle", iob_rvalid_o, 0);
          check("err_idle", err_o, 0);
        end
      end
      prev_ready = iob_ready_o; pc = cke_i; prst = rst_i;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input int lat);
    bit       acc;
    axi_exp_t x;
    rsp_exp_t r;
    iob_avalid_i = 1; iob_addr_i = a; iob_wdata_i = d; iob_wstrb_i = s;
    acc = 0;
    for (int n = 0; n < 500 && !acc; n++) begin
      @(negedge clk);
      if (iob_ready_o && cke_i && !rst_i) begin
        acc = 1;
        x.is_rd = (s == 0); x.addr = a; x.data = d; x.strb = s;
        axi_q.push_back(x);
        r.is_rd = (s == 0); r.err = err_addr(a); r.lat = lat; r.cyc0 = cyc;
        r.rdata = model_mem[a[7:2]];
        if (s != 0 && !err_addr(a)) model_mem[a[7:2]] = merge(model_mem[a[7:2]], d, s);
        rsp_q.push_back(r);
      end
      @(posedge clk);
      #1;
    end
    iob_avalid_i = 0;
    if (!acc) check("issue_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 3000 && rsp_q.size() != 0; n++) @(posedge clk);
    #1;
    check("drain_timeout", rsp_q.size(), 0);
  endtask

  initial begin : main
    logic [31:0] save, a;
    logic [3:0]  s;
    for (int i = 0; i < 64; i++) begin
      model_mem[i] = 32'h1000_0000 + i;
      slv_mem[i]   = 32'h1000_0000 + i;
    end
    model_mem[16] = 32'hDEAD_BEEF;
    slv_mem[16]   = 32'hDEAD_BEEF;
    rst_i = 1; iob_avalid_i = 0; iob_addr_i = '0; iob_wdata_i = '0; iob_wstrb_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 0;

    @(negedge clk);
    check("rst_ready", iob_ready_o, 1);
    check("rst_rvalid", iob_rvalid_o, 0);
    check("rst_rdata", iob_rdata_o, 0);
    check("rst_err", err_o, 0);
    check("rst_valids", {axil_awvalid_o, axil_wvalid_o, axil_arvalid_o}, 0);
    check("rst_readies", {axil_bready_o, axil_rready_o}, 0);
    check("rst_payload", {axil_awaddr_o, axil_wstrb_o}, 0);
    check("rst_wdata", axil_wdata_o, 0);
    @(posedge clk);
    #1;

    // Zero-wait slave: basic read, back-to-back traffic, and error responses.
    mode = M_FAST;
    issue(32'h40, 32'h0, 4'h0, 3);
    issue(32'h0, 32'h0, 4'h0, 3);
    issue(32'h4, 32'hCAFE_F00D, 4'hF, 3);
    issue(32'h4, 32'h0, 4'h0, 3);
    issue(32'h10, 32'h1234_5678, 4'b0011, 3);
    issue(32'h10, 32'h0, 4'h0, 3);
    issue(32'hC0, 32'h0, 4'h0, 3);
    issue(32'hC4, 32'h5555_AAAA, 4'hF, 3);
    issue(32'hC4, 32'h0, 4'h0, 3);
    wait_idle();

    // Reset while AW/W are waiting for a ready that never comes.
    mode = M_HOLD;
    save = model_mem[2];
    issue(32'h8, 32'hABCD_0123, 4'hF, -1);
    repeat (2) @(negedge clk);
    check("pre_rst_awvalid", {axil_awvalid_o, axil_wvalid_o}, 2'b11);
    @(posedge clk);
    #1 rst_i = 1;
    @(posedge clk);
    #1 rst_i = 0;
    rsp_q.delete();
    axi_q.delete();
    model_mem[2] = save;
    @(negedge clk);
    check("post_rst_ready", iob_ready_o, 1);
    check("post_rst_valids", {axil_awvalid_o, axil_wvalid_o, axil_arvalid_o}, 0);
    check("post_rst_readies", {axil_bready_o, axil_rready_o}, 0);
    check("post_rst_awaddr", axil_awaddr_o, 0);
    @(posedge clk);
    #1;
    mode = M_FAST;
    issue(32'h8, 32'h0, 4'h0, 3);
    wait_idle();

    // Freeze mid-READ while arready is offered: it must not be sampled.
    mode = M_HOLD;
    issue(32'h14, 32'h0, 4'h0, -1);
    @(negedge clk);
    check("frz_arvalid_pre", axil_arvalid_o, 1);
    @(posedge clk);
    #1;
    cke_dir = 0;
    frz = 1;
    repeat (5) begin
      @(negedge clk);
      check("frz_arvalid", axil_arvalid_o, 1);
      check("frz_araddr", axil_araddr_o, 32'h14);
      check("frz_ready", iob_ready_o, 0);
      check("frz_rready_rvalid", {axil_rready_o, iob_rvalid_o}, 0);
    end
    @(posedge clk);
    #1;
    cke_dir = 1;
    frz = 0;
    mode = M_FAST;
    wait_idle();

    // Random traffic with random ready/valid timing, spurious responses and stalls.
    mode = M_RND;
    cke_rand = 1;
    for (int t = 0; t < 300; t++) begin
      a = ($urandom % 64) * 4;
      s = ($urandom % 2) ? 4'h0 : 4'($urandom_range(15, 1));
      issue(a, $urandom, s, -1);
      repeat ($urandom % 3) begin
        @(posedge clk);
        #1;
      end
    end
    cke_rand = 0;
    wait_idle();
    check("axi_q_drained", axi_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
